motor_current_control: RTL and testbench
========================================

MOTOR_CURRENT_CONTROL -- requirements
Module: motor_current_control

Interface
REQ-001 Parameter PWM_PERIOD, default 13'd2500, meaning the PWM period in clk cycles; the counter runs 0..PWM_PERIOD-1.
REQ-002 Parameter RAMP_DIV, default 16'd1000, meaning clk cycles per upward ramp tick.
REQ-003 Parameter RAMP_STEP, default 13'd8, meaning the duty increment per ramp tick.
REQ-004 Parameter TILT_LIMIT, default 10'sd45, meaning the roll magnitude above which a tilt fault is raised.
REQ-005 Parameter CURRENT_LIMIT, default 12'd3000, meaning the overcurrent threshold in ADC counts.
REQ-006 Parameter OC_COUNT, default 3'd3, meaning the number of consecutive over-limit samples that raises a fault.
REQ-007 Ports:
  - clk  in  1  system clock.
  - rst_n  in  1  synchronous, active-low reset.
  - AssistanceRequirement  in  13  unsigned torque demand from the assistance calculator.
  - ResolvedRoll  in  10 signed  IMU roll.
  - brake  in  1  brake lever, active-high.
  - MeasuredCurrent  in  12  motor current ADC sample.
  - current_valid  in  1  one-cycle strobe marking a new MeasuredCurrent sample.
  - pwm_out  out  1  motor gate drive.
  - motor_enable  out  1  bridge enable.
  - duty  out  13  duty currently applied.
  - state  out  2  IDLE=0, RUN=1, BRAKE=2, FAULT=3.
  - fault_code  out  2  0 none, 1 tilt, 2 overcurrent.

Function
REQ-008 Target SHALL be min(AssistanceRequirement, PWM_PERIOD).
REQ-009 In RUN, the internal duty SHALL rise by RAMP_STEP on each ramp tick, saturating at target, and SHALL drop to target on the cycle after the target falls below it (no downward ramp).
REQ-010 The ramp tick counter SHALL run freely modulo RAMP_DIV from reset.
REQ-011 The PWM counter SHALL wrap from PWM_PERIOD-1 to 0; the applied duty SHALL be loaded from the internal duty only at the wrap, so there are no mid-period glitches.
REQ-012 pwm_out SHALL equal motor_enable AND (counter < applied duty), registered.
REQ-013 IDLE->RUN SHALL occur when AssistanceRequirement != 0, brake=0, and no fault condition is present.
REQ-014 RUN->IDLE SHALL occur when target=0 and the internal duty reaches 0.
REQ-015 Any state except FAULT SHALL go to BRAKE when brake=1; BRAKE->IDLE SHALL occur when brake=0.
REQ-016 Tilt condition: |ResolvedRoll| > TILT_LIMIT, with -512 treated as exceeding the limit.
REQ-017 Overcurrent condition: OC_COUNT consecutive current_valid samples with MeasuredCurrent > CURRENT_LIMIT; a sample at or below the limit clears the count; cycles without current_valid do not change it.
REQ-018 Either condition SHALL send any state to FAULT and latch fault_code; tilt has priority if both occur in the same cycle; fault has priority over brake.
REQ-019 FAULT->IDLE SHALL occur only when the tilt condition is false, AssistanceRequirement=0 and brake=1 in the same cycle; fault_code then clears and the overcurrent count resets.
REQ-020 Entering BRAKE or FAULT SHALL clear the internal duty and the applied duty immediately and drive pwm_out=0 on the next cycle, without waiting for a PWM wrap.
REQ-021 motor_enable SHALL be 1 only in RUN.
REQ-022 State changes SHALL register one cycle after the causing input.

Reset
REQ-023 While rst_n=0 at a clk edge, the block SHALL set: state=IDLE, duty=0, pwm_out=0, motor_enable=0, fault_code=0, PWM counter=0, ramp counter=0, overcurrent count=0.
REQ-024 Reset asserted mid-period or in FAULT SHALL take effect on the next edge with no exceptions.

Structure
REQ-025 The state enum, the fault_code enum and the default limits SHALL live in the shared package motor_pkg.
REQ-026 PWM counter/comparator SHALL be a sub-module pwm_generator (ports: clk, rst_n, duty_in, force_off, pwm_out, wrap).

Verification
REQ-027 AssistanceRequirement=800, brake=0, roll=0 -> RUN; duty increases by 8 every 1000 cycles and reaches 800 after 100 ticks; pwm_out high 800 of every 2500 cycles.
REQ-028 AssistanceRequirement=5000 -> duty saturates at 2500; pwm_out is continuously high.
REQ-029 brake=1 mid-period while duty=400 -> pwm_out=0 the next cycle and state=BRAKE; brake=0 -> IDLE, then RUN, with the ramp restarting from 0.
REQ-030 ResolvedRoll=46 (then -512 in a separate run) -> FAULT and fault_code=1; exit only after roll=10, AssistanceRequirement=0 and brake=1.
REQ-031 MeasuredCurrent=3001 on 2 strobes, then 2900, then 3001 on 3 strobes -> no fault until the third consecutive strobe, then FAULT and fault_code=2.
REQ-032 rst_n=0 for one cycle while in RUN with duty=1200 -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and default limits for the motor current control block.
// Contents:
//   motor_state_t  - controller state encoding, as presented on the state port
//   fault_code_t   - latched fault cause, as presented on the fault_code port
//   DEF_*          - default limits used as parameter defaults by the RTL
package motor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BRAKE = 2'd2,
      ST_FAULT = 2'd3
   } motor_state_t;

   typedef enum logic [1:0] {
      FC_NONE        = 2'd0,
      FC_TILT        = 2'd1,
      FC_OVERCURRENT = 2'd2
   } fault_code_t;

   localparam logic        [12:0] DEF_PWM_PERIOD    = 13'd2500;
   localparam logic        [15:0] DEF_RAMP_DIV      = 16'd1000;
   localparam logic        [12:0] DEF_RAMP_STEP     = 13'd8;
   localparam logic signed [9:0]  DEF_TILT_LIMIT    = 10'sd45;
   localparam logic        [11:0] DEF_CURRENT_LIMIT = 12'd3000;
   localparam logic        [2:0]  DEF_OC_COUNT      = 3'd3;

endpackage

// File: rtl/pwm_generator.sv
// PWM counter and comparator.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   duty_in     - applied duty (held stable by the caller between wraps)
//   force_off   - when high, pwm_out is driven low on the next edge
//   pwm_out     - registered gate drive: !force_off && (counter < duty_in)
//   wrap        - high during the last count of the period (counter == PWM_PERIOD-1)
module pwm_generator
   import motor_pkg::*;
#(
   parameter logic [12:0] PWM_PERIOD = DEF_PWM_PERIOD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [12:0] duty_in,
   input  logic        force_off,
   output logic        pwm_out,
   output logic        wrap
);

   logic [12:0] cnt;

   assign wrap = (cnt == (PWM_PERIOD - 13'd1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= 13'd0;
         pwm_out <= 1'b0;
      end else begin
         cnt     <= wrap ? 13'd0 : (cnt + 13'd1);
         pwm_out <= !force_off && (cnt < duty_in);
      end
   end

endmodule

// File: rtl/motor_current_control.sv
// Motor current control: assistance-driven duty ramp, brake handling, tilt and
// overcurrent protection, and a PWM stage whose duty only changes at the wrap.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   AssistanceRequirement  - unsigned torque demand (clamped to PWM_PERIOD)
//   ResolvedRoll           - signed IMU roll, two's complement
//   brake                  - brake lever, active-high
//   MeasuredCurrent        - motor current ADC sample
//   current_valid          - one-cycle strobe qualifying MeasuredCurrent
//   pwm_out                - motor gate drive
//   motor_enable           - bridge enable, high only in RUN
//   duty                   - duty currently applied to the PWM stage
//   state                  - IDLE=0, RUN=1, BRAKE=2, FAULT=3
//   fault_code             - 0 none, 1 tilt, 2 overcurrent
module motor_current_control
   import motor_pkg::*;
#(
   parameter logic        [12:0] PWM_PERIOD    = DEF_PWM_PERIOD,
   parameter logic        [15:0] RAMP_DIV      = DEF_RAMP_DIV,
   parameter logic        [12:0] RAMP_STEP     = DEF_RAMP_STEP,
   parameter logic signed [9:0]  TILT_LIMIT    = DEF_TILT_LIMIT,
   parameter logic        [11:0] CURRENT_LIMIT = DEF_CURRENT_LIMIT,
   parameter logic        [2:0]  OC_COUNT      = DEF_OC_COUNT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [12:0] AssistanceRequirement,
   input  logic [9:0]  ResolvedRoll,
   input  logic        brake,
   input  logic [11:0] MeasuredCurrent,
   input  logic        current_valid,
   output logic        pwm_out,
   output logic        motor_enable,
   output logic [12:0] duty,
   output logic [1:0]  state,
   output logic [1:0]  fault_code
);

   // Upward ramp with saturation at the target; a target below the current
   // duty is taken immediately.
   function automatic logic [12:0] ramp_next(input logic [12:0] cur,
                                             input logic [12:0] tgt,
                                             input logic        tick,
                                             input logic [12:0] step);
      logic [13:0] sum;
      sum = {1'b0, cur} + {1'b0, step};
      if (cur > tgt)
         return tgt;
      else if (tick)
         return (sum > {1'b0, tgt}) ? tgt : sum[12:0];
      else
         return cur;
   endfunction

   // Symmetric magnitude test done as a two-sided compare so that -512,
   // whose magnitude is not representable in 10 bits, lands on the
   // exceeding side.
   function automatic logic tilt_exceeded(input logic signed [9:0] roll,
                                          input logic signed [9:0] limit);
      return (roll > limit) || (roll < -limit);
   endfunction

   motor_state_t cur_state, nxt_state;
   fault_code_t  fault_q, fault_d;

   logic signed [9:0] roll_s;
   logic [12:0] target;
   logic [12:0] duty_int;
   logic [12:0] duty_app;
   logic [15:0] ramp_cnt;
   logic [2:0]  oc_cnt;
   logic        ramp_tick;
   logic        tilt;
   logic        over_limit;
   logic        oc_hit;
   logic        wrap;
   logic        force_off;
   logic        fault_exit;

   assign roll_s     = $signed(ResolvedRoll);
   assign tilt       = tilt_exceeded(roll_s, TILT_LIMIT);
   assign target     = (AssistanceRequirement > PWM_PERIOD) ? PWM_PERIOD : AssistanceRequirement;
   assign ramp_tick  = (ramp_cnt == (RAMP_DIV - 16'd1));
   assign over_limit = (MeasuredCurrent > CURRENT_LIMIT);
   // The strobe that would bring the consecutive count up to OC_COUNT is the
   // one that raises the fault.
   assign oc_hit     = current_valid && over_limit &&
                       (({1'b0, oc_cnt} + 4'd1) >= {1'b0, OC_COUNT});

   always_comb begin
      nxt_state  = cur_state;
      fault_d    = fault_q;
      fault_exit = 1'b0;
      if (cur_state == ST_FAULT) begin
         if (!tilt && !oc_hit && (AssistanceRequirement == 13'd0) && brake) begin
            nxt_state  = ST_IDLE;
            fault_d    = FC_NONE;
            fault_exit = 1'b1;
         end
      end else if (tilt) begin
         nxt_state = ST_FAULT;
         fault_d   = FC_TILT;
      end else if (oc_hit) begin
         nxt_state = ST_FAULT;
         fault_d   = FC_OVERCURRENT;
      end else if (brake) begin
         nxt_state = ST_BRAKE;
      end else begin
         case (cur_state)
            ST_IDLE:  if (AssistanceRequirement != 13'd0) nxt_state = ST_RUN;
            ST_RUN:   if ((target == 13'd0) && (duty_int == 13'd0)) nxt_state = ST_IDLE;
            ST_BRAKE: nxt_state = ST_IDLE;
            default:  nxt_state = cur_state;
         endcase
      end
   end

   // Gate drive is cut on the same edge the state leaves RUN, so pwm_out
   // never lags motor_enable.
   assign force_off = (nxt_state != ST_RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_state    <= ST_IDLE;
         fault_q      <= FC_NONE;
         motor_enable <= 1'b0;
         duty_int     <= 13'd0;
         duty_app     <= 13'd0;
         ramp_cnt     <= 16'd0;
         oc_cnt       <= 3'd0;
      end else begin
         cur_state    <= nxt_state;
         fault_q      <= fault_d;
         motor_enable <= (nxt_state == ST_RUN);
         ramp_cnt     <= ramp_tick ? 16'd0 : (ramp_cnt + 16'd1);

         if (fault_exit)
            oc_cnt <= 3'd0;
         else if (current_valid)
            oc_cnt <= !over_limit ? 3'd0 :
                      (oc_cnt < OC_COUNT) ? (oc_cnt + 3'd1) : oc_cnt;

         // BRAKE/FAULT clear both duty copies at once instead of waiting for
         // the next PWM wrap.
         if ((nxt_state == ST_BRAKE) || (nxt_state == ST_FAULT)) begin
            duty_int <= 13'd0;
            duty_app <= 13'd0;
         end else begin
            duty_int <= (cur_state == ST_RUN) ?
                        ramp_next(duty_int, target, ramp_tick, RAMP_STEP) : 13'd0;
            if (wrap)
               duty_app <= duty_int;
         end
      end
   end

   pwm_generator #(
      .PWM_PERIOD (PWM_PERIOD)
   ) u_pwm (
      .clk       (clk),
      .rst_n     (rst_n),
      .duty_in   (duty_app),
      .force_off (force_off),
      .pwm_out   (pwm_out),
      .wrap      (wrap)
   );

   assign duty       = duty_app;
   assign state      = cur_state;
   assign fault_code = fault_q;

endmodule

// File: tb/tb_motor_current_control.sv
// Directed bench for motor_current_control. RAMP_DIV is shortened to 10 so
// full ramps fit in a few thousand cycles; the other parameters keep their
// defaults. Edge numbers are counted from the last reset edge (edge 0).
module tb_motor_current_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [12:0] ar;
   logic [9:0]  roll;
   logic        brake;
   logic [11:0] cur;
   logic        cur_vld;
   logic        pwm_out;
   logic        motor_enable;
   logic [12:0] duty;
   logic [1:0]  state;
   logic [1:0]  fault_code;

   int total = 0;
   int bad   = 0;
   int edge_no = 0;

   always #5 clk = ~clk;

   motor_current_control #(
      .RAMP_DIV (16'd10)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .AssistanceRequirement (ar),
      .ResolvedRoll          (roll),
      .brake                 (brake),
      .MeasuredCurrent       (cur),
      .current_valid         (cur_vld),
      .pwm_out               (pwm_out),
      .motor_enable          (motor_enable),
      .duty                  (duty),
      .state                 (state),
      .fault_code            (fault_code)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         edge_no++;
      end
   endtask

   task automatic goto(input int t);
      step(t - edge_no);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      edge_no = 0;
   endtask

   task automatic strobe(input logic [11:0] val);
      cur = val; cur_vld = 1'b1;
      step(1);
      cur = 12'd4000; cur_vld = 1'b0;
   endtask

   task automatic test_reset();
      ar = 13'd800; roll = 10'd0; brake = 1'b0; cur = 12'd0; cur_vld = 1'b0;
      rst_n = 1'b0;
      step(3);
      total++; if (state !== 2'd0)      begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++; if (duty !== 13'd0)      begin bad++; $display("FAIL reset_duty: got %0d want 0", duty); end
      total++; if (pwm_out !== 1'b0)    begin bad++; $display("FAIL reset_pwm: got %0b want 0", pwm_out); end
      total++; if (motor_enable !== 1'b0) begin bad++; $display("FAIL reset_en: got %0b want 0", motor_enable); end
      total++; if (fault_code !== 2'd0) begin bad++; $display("FAIL reset_fault: got %0d want 0", fault_code); end
   endtask

   task automatic test_ramp();
      int highs;
      ar = 13'd800; roll = 10'd0; brake = 1'b0;
      do_reset();
      goto(1);
      total++; if (state !== 2'd1)        begin bad++; $display("FAIL ramp_run: got %0d want 1", state); end
      total++; if (motor_enable !== 1'b1) begin bad++; $display("FAIL ramp_en: got %0b want 1", motor_enable); end
      goto(2499);
      total++; if (duty !== 13'd0)   begin bad++; $display("FAIL ramp_pre_wrap: got %0d want 0", duty); end
      goto(2500);
      total++; if (duty !== 13'd800) begin bad++; $display("FAIL ramp_duty: got %0d want 800", duty); end
      highs = 0;
      for (int i = 0; i < 2500; i++) begin
         step(1);
         if (pwm_out === 1'b1) highs++;
      end
      total++; if (highs != 800) begin bad++; $display("FAIL ramp_pwm_high: got %0d want 800", highs); end
   endtask

   task automatic test_saturate();
      int highs;
      ar = 13'd5000; roll = 10'd0; brake = 1'b0;
      do_reset();
      goto(2500);
      // 249 ticks of 8 before the first wrap
      total++; if (duty !== 13'd1992) begin bad++; $display("FAIL sat_first_wrap: got %0d want 1992", duty); end
      goto(5000);
      total++; if (duty !== 13'd2500) begin bad++; $display("FAIL sat_duty: got %0d want 2500", duty); end
      highs = 0;
      for (int i = 0; i < 2500; i++) begin
         step(1);
         if (pwm_out === 1'b1) highs++;
      end
      total++; if (highs != 2500) begin bad++; $display("FAIL sat_pwm_high: got %0d want 2500", highs); end
      ar = 13'd0;
      goto(7501);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL drop_still_run: got %0d want 1", state); end
      goto(7502);
      total++; if (state !== 2'd0)     begin bad++; $display("FAIL drop_idle: got %0d want 0", state); end
      total++; if (pwm_out !== 1'b0)   begin bad++; $display("FAIL drop_pwm: got %0b want 0", pwm_out); end
   endtask

   task automatic test_brake();
      ar = 13'd400; roll = 10'd0; brake = 1'b0;
      do_reset();
      goto(2600);
      total++; if (duty !== 13'd400) begin bad++; $display("FAIL brk_pre_duty: got %0d want 400", duty); end
      total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL brk_pre_pwm: got %0b want 1", pwm_out); end
      brake = 1'b1;
      goto(2601);
      total++; if (state !== 2'd2)        begin bad++; $display("FAIL brk_state: got %0d want 2", state); end
      total++; if (pwm_out !== 1'b0)      begin bad++; $display("FAIL brk_pwm: got %0b want 0", pwm_out); end
      total++; if (duty !== 13'd0)        begin bad++; $display("FAIL brk_duty: got %0d want 0", duty); end
      total++; if (motor_enable !== 1'b0) begin bad++; $display("FAIL brk_en: got %0b want 0", motor_enable); end
      goto(2605);
      total++; if (state !== 2'd2) begin bad++; $display("FAIL brk_hold: got %0d want 2", state); end
      brake = 1'b0;
      goto(2606);
      total++; if (state !== 2'd0) begin bad++; $display("FAIL brk_idle: got %0d want 0", state); end
      goto(2607);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL brk_rerun: got %0d want 1", state); end
      goto(4999);
      total++; if (duty !== 13'd0)   begin bad++; $display("FAIL brk_restart_duty: got %0d want 0", duty); end
      total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL brk_restart_pwm: got %0b want 0", pwm_out); end
      goto(5000);
      total++; if (duty !== 13'd400) begin bad++; $display("FAIL brk_reload: got %0d want 400", duty); end
   endtask

   task automatic test_tilt();
      ar = 13'd800; roll = 10'd0; brake = 1'b0;
      do_reset();
      goto(20);
      roll = 10'd45;
      goto(21);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL tilt_pos45: got %0d want 1", state); end
      roll = 10'h3D3; // -45
      goto(22);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL tilt_neg45: got %0d want 1", state); end
      roll = 10'd46;
      goto(23);
      total++; if (state !== 2'd3)        begin bad++; $display("FAIL tilt_state: got %0d want 3", state); end
      total++; if (fault_code !== 2'd1)   begin bad++; $display("FAIL tilt_code: got %0d want 1", fault_code); end
      total++; if (pwm_out !== 1'b0)      begin bad++; $display("FAIL tilt_pwm: got %0b want 0", pwm_out); end
      total++; if (motor_enable !== 1'b0) begin bad++; $display("FAIL tilt_en: got %0b want 0", motor_enable); end
      roll = 10'd10; ar = 13'd0; brake = 1'b0;
      goto(25);
      total++; if (state !== 2'd3) begin bad++; $display("FAIL tilt_no_brake_exit: got %0d want 3", state); end
      roll = 10'd46; brake = 1'b1;
      goto(27);
      total++; if (state !== 2'd3) begin bad++; $display("FAIL tilt_still_tilted: got %0d want 3", state); end
      roll = 10'd10; ar = 13'd5; brake = 1'b1;
      goto(28);
      total++; if (state !== 2'd3) begin bad++; $display("FAIL tilt_ar_nonzero: got %0d want 3", state); end
      ar = 13'd0;
      goto(29);
      total++; if (state !== 2'd0)      begin bad++; $display("FAIL tilt_exit: got %0d want 0", state); end
      total++; if (fault_code !== 2'd0) begin bad++; $display("FAIL tilt_code_clr: got %0d want 0", fault_code); end

      ar = 13'd800; roll = 10'd0; brake = 1'b0;
      do_reset();
      goto(5);
      roll = 10'h200; brake = 1'b1; // -512 together with brake
      goto(6);
      total++; if (state !== 2'd3)      begin bad++; $display("FAIL tilt512_state: got %0d want 3", state); end
      total++; if (fault_code !== 2'd1) begin bad++; $display("FAIL tilt512_code: got %0d want 1", fault_code); end
      rst_n = 1'b0;
      step(1);
      total++; if (state !== 2'd0)      begin bad++; $display("FAIL rst_in_fault_state: got %0d want 0", state); end
      total++; if (fault_code !== 2'd0) begin bad++; $display("FAIL rst_in_fault_code: got %0d want 0", fault_code); end
      rst_n = 1'b1; roll = 10'd0; brake = 1'b0;
   endtask

   task automatic test_overcurrent();
      ar = 13'd800; roll = 10'd0; brake = 1'b0; cur = 12'd4000; cur_vld = 1'b0;
      do_reset();
      goto(5);
      strobe(12'd3001); step(2);
      strobe(12'd3001); step(2);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL oc_two: got %0d want 1", state); end
      strobe(12'd2900); step(2);
      strobe(12'd3001); step(2);
      strobe(12'd3001); step(2);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL oc_cleared: got %0d want 1", state); end
      strobe(12'd3000); step(2);
      strobe(12'd3001); step(2);
      strobe(12'd3001); step(2);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL oc_limit_clears: got %0d want 1", state); end
      strobe(12'd3001);
      total++; if (state !== 2'd3)      begin bad++; $display("FAIL oc_state: got %0d want 3", state); end
      total++; if (fault_code !== 2'd2) begin bad++; $display("FAIL oc_code: got %0d want 2", fault_code); end
      step(2);
      ar = 13'd0; brake = 1'b1;
      step(1);
      total++; if (state !== 2'd0)      begin bad++; $display("FAIL oc_exit: got %0d want 0", state); end
      total++; if (fault_code !== 2'd0) begin bad++; $display("FAIL oc_code_clr: got %0d want 0", fault_code); end
      ar = 13'd800; brake = 1'b0;
      step(1);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL oc_rerun: got %0d want 1", state); end
      strobe(12'd3001); step(2);
      strobe(12'd3001); step(2);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL oc_count_reset: got %0d want 1", state); end
      roll = 10'd46;
      strobe(12'd3001);
      total++; if (state !== 2'd3)      begin bad++; $display("FAIL prio_state: got %0d want 3", state); end
      total++; if (fault_code !== 2'd1) begin bad++; $display("FAIL prio_code: got %0d want 1", fault_code); end
      roll = 10'd0;
   endtask

   task automatic test_reset_mid_run();
      ar = 13'd1200; roll = 10'd0; brake = 1'b0; cur_vld = 1'b0;
      do_reset();
      goto(2600);
      total++; if (duty !== 13'd1200) begin bad++; $display("FAIL mid_pre_duty: got %0d want 1200", duty); end
      total++; if (pwm_out !== 1'b1)  begin bad++; $display("FAIL mid_pre_pwm: got %0b want 1", pwm_out); end
      rst_n = 1'b0;
      step(1);
      total++; if (state !== 2'd0)        begin bad++; $display("FAIL mid_state: got %0d want 0", state); end
      total++; if (duty !== 13'd0)        begin bad++; $display("FAIL mid_duty: got %0d want 0", duty); end
      total++; if (pwm_out !== 1'b0)      begin bad++; $display("FAIL mid_pwm: got %0b want 0", pwm_out); end
      total++; if (motor_enable !== 1'b0) begin bad++; $display("FAIL mid_en: got %0b want 0", motor_enable); end
      total++; if (fault_code !== 2'd0)   begin bad++; $display("FAIL mid_fault: got %0d want 0", fault_code); end
      rst_n = 1'b1;
      edge_no = 0;
      goto(1);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL mid_rerun: got %0d want 1", state); end
      // the PWM counter restarted at the reset edge, so the next load is at edge 2500
      goto(2499);
      total++; if (duty !== 13'd0)    begin bad++; $display("FAIL mid_cnt_restart: got %0d want 0", duty); end
      goto(2500);
      total++; if (duty !== 13'd1200) begin bad++; $display("FAIL mid_reload: got %0d want 1200", duty); end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_saturate();
      test_brake();
      test_tilt();
      test_overcurrent();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
